// File: rtl/ground_tile_scanner.sv
// rtl/ground_tile_scanner.sv - raster position to ground tile ROM address, 2-stage color/opaque pipeline
// Optional GROUND_SCROLL_EN macro enables the per-frame horizontal scroll phase.
module ground_tile_scanner #(
    parameter int          TILE_W     = 20,
    parameter int          TILE_H     = 20,
    parameter int          GROUND_TOP = 400,
    parameter logic [11:0] KEY_COLOR  = 12'h808
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic [2:0]  scroll_step,
    output logic [8:0]  tile_read_address,
    input  logic [11:0] tile_color,
    output logic        ground_valid,
    output logic [11:0] ground_color,
    output logic        ground_opaque
);

    logic [4:0]  scroll_phase;

    logic [4:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [8:0]  row_base_q, row_base_d;
    logic [8:0]  tile_read_address_q, tile_read_address_d;
    logic        in_ground_s1_q, in_ground_s1_d;
    logic        valid_s1_q, valid_s1_d;
    logic [11:0] ground_color_q, ground_color_d;
    logic        ground_opaque_q, ground_opaque_d;
    logic        ground_valid_q, ground_valid_d;
    logic        line_start;

`ifdef GROUND_SCROLL_EN
    logic [4:0] scroll_phase_q, scroll_phase_d;
    logic [5:0] phase_sum;

    // Sum never exceeds 19+7, so one conditional subtract is a full modulo.
    always_comb begin
        phase_sum      = {1'b0, scroll_phase_q} + {3'b000, scroll_step};
        scroll_phase_d = scroll_phase_q;
        if (frame_start) begin
            if (phase_sum >= 6'(TILE_W)) begin
                scroll_phase_d = 5'(phase_sum - 6'(TILE_W));
            end else begin
                scroll_phase_d = phase_sum[4:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scroll_phase_q <= '0;
        end else begin
            scroll_phase_q <= scroll_phase_d;
        end
    end

    assign scroll_phase = scroll_phase_q;
`else
    logic unused_scroll_inputs;
    assign unused_scroll_inputs = ^{frame_start, scroll_step};
    assign scroll_phase         = '0;
`endif

    always_comb begin
        line_start = pixel_valid && (DrawX == 10'd0);

        col_d = col_q;
        if (line_start) begin
            col_d = scroll_phase;
        end else if (pixel_valid) begin
            col_d = (col_q == 5'(TILE_W - 1)) ? 5'd0 : col_q + 5'd1;
        end

        // Row tracks (DrawY - GROUND_TOP) mod TILE_H with row_base = row*TILE_W, no divider.
        row_d      = row_q;
        row_base_d = row_base_q;
        if (line_start) begin
            if (DrawY == 10'(GROUND_TOP)) begin
                row_d      = '0;
                row_base_d = '0;
            end else if (DrawY > 10'(GROUND_TOP)) begin
                if (row_q == 5'(TILE_H - 1)) begin
                    row_d      = '0;
                    row_base_d = '0;
                end else begin
                    row_d      = row_q + 5'd1;
                    row_base_d = row_base_q + 9'(TILE_W);
                end
            end
        end

        tile_read_address_d = row_base_d + {4'b0000, col_d};
        in_ground_s1_d      = pixel_valid && (DrawY >= 10'(GROUND_TOP));
        valid_s1_d          = pixel_valid;

        ground_color_d  = tile_color;
        ground_opaque_d = in_ground_s1_q && (tile_color != KEY_COLOR);
        ground_valid_d  = valid_s1_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q               <= '0;
            row_q               <= '0;
            row_base_q          <= '0;
            tile_read_address_q <= '0;
            in_ground_s1_q      <= 1'b0;
            valid_s1_q          <= 1'b0;
            ground_color_q      <= '0;
            ground_opaque_q     <= 1'b0;
            ground_valid_q      <= 1'b0;
        end else begin
            col_q               <= col_d;
            row_q               <= row_d;
            row_base_q          <= row_base_d;
            tile_read_address_q <= tile_read_address_d;
            in_ground_s1_q      <= in_ground_s1_d;
            valid_s1_q          <= valid_s1_d;
            ground_color_q      <= ground_color_d;
            ground_opaque_q     <= ground_opaque_d;
            ground_valid_q      <= ground_valid_d;
        end
    end

    assign tile_read_address = tile_read_address_q;
    assign ground_color      = ground_color_q;
    assign ground_opaque     = ground_opaque_q;
    assign ground_valid      = ground_valid_q;

endmodule

// File: tb/tb_ground_tile_scanner.sv
// tb/tb_ground_tile_scanner.sv - directed self-checking bench for ground_tile_scanner
module tb_ground_tile_scanner;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pixel_valid;
    logic        frame_start;
    logic [2:0]  scroll_step;
    logic [8:0]  tile_read_address;
    logic [11:0] tile_color;
    logic        ground_valid;
    logic [11:0] ground_color;
    logic        ground_opaque;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_row   = 0;
    int exp_phase = 0;

    ground_tile_scanner dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .DrawX             (DrawX),
        .DrawY             (DrawY),
        .pixel_valid       (pixel_valid),
        .frame_start       (frame_start),
        .scroll_step       (scroll_step),
        .tile_read_address (tile_read_address),
        .tile_color        (tile_color),
        .ground_valid      (ground_valid),
        .ground_color      (ground_color),
        .ground_opaque     (ground_opaque)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Every third address returns the transparent key color.
    function automatic logic [11:0] rom(input logic [8:0] a);
        if ((a % 3) == 0) return 12'h808;
        return {3'b101, a};
    endfunction

    always_comb tile_color = rom(tile_read_address);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic advance_phase(input int step);
`ifdef GROUND_SCROLL_EN
        exp_phase = (exp_phase + step) % 20;
`else
        exp_phase = exp_phase + 0 * step;
`endif
    endtask

    task automatic pulse_frame(input logic [2:0] step);
        scroll_step = step;
        frame_start = 1'b1;
        pixel_valid = 1'b0;
        tick();
        frame_start = 1'b0;
        advance_phase(int'(step));
    endtask

    // Drives pixels 0..nx-1 of line y, optionally with frame_start on DrawX==0.
    task automatic drive_line(input int y, input int nx, input bit fs_at0, input logic [2:0] fs_step);
        logic [8:0]  exp_addr;
        logic [8:0]  prev_addr;
        logic [11:0] pc;
        int          line_phase;
        prev_addr  = '0;
        line_phase = exp_phase;
        if (y == 400) exp_row = 0;
        else if (y > 400) exp_row = (exp_row + 1) % 20;
        for (int x = 0; x < nx; x++) begin
            DrawX       = 10'(x);
            DrawY       = 10'(y);
            pixel_valid = 1'b1;
            frame_start = fs_at0 && (x == 0);
            scroll_step = fs_step;
            tick();
            frame_start = 1'b0;
            exp_addr = 9'(exp_row * 20 + (line_phase + x) % 20);
            total_cnt++;
            if (tile_read_address !== exp_addr)
                $display("FAIL addr y=%0d x=%0d got %0d want %0d", y, x, tile_read_address, exp_addr);
            else pass_cnt++;
            if (x == 0) begin
                total_cnt++;
                if (ground_valid !== 1'b0)
                    $display("FAIL early_valid y=%0d got %b want 0", y, ground_valid);
                else pass_cnt++;
            end else begin
                pc = rom(prev_addr);
                total_cnt++;
                if (ground_valid !== 1'b1 || ground_color !== pc || ground_opaque !== (y >= 400 && pc != 12'h808))
                    $display("FAIL pixel y=%0d x=%0d got v=%b c=%h o=%b want v=1 c=%h o=%b",
                             y, x - 1, ground_valid, ground_color, ground_opaque, pc, (y >= 400 && pc != 12'h808));
                else pass_cnt++;
            end
            prev_addr = exp_addr;
        end
        if (fs_at0) advance_phase(int'(fs_step));
        idle(1);
        pc = rom(prev_addr);
        total_cnt++;
        if (ground_valid !== 1'b1 || ground_color !== pc || ground_opaque !== (y >= 400 && pc != 12'h808))
            $display("FAIL last_pixel y=%0d got v=%b c=%h o=%b want v=1 c=%h", y, ground_valid, ground_color, ground_opaque, pc);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if (ground_valid !== 1'b0)
            $display("FAIL valid_drop y=%0d got %b want 0", y, ground_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        scroll_step = '0;
        #13;
        total_cnt++;
        if (tile_read_address !== 9'd0 || ground_valid !== 1'b0 || ground_color !== 12'd0 || ground_opaque !== 1'b0)
            $display("FAIL reset_state got a=%0d v=%b c=%h o=%b want all 0", tile_read_address, ground_valid, ground_color, ground_opaque);
        else pass_cnt++;
        Reset_n = 1'b1;
        idle(3);
        total_cnt++;
        if (ground_valid !== 1'b0 || ground_opaque !== 1'b0)
            $display("FAIL idle_after_reset got v=%b o=%b want 0 0", ground_valid, ground_opaque);
        else pass_cnt++;
    endtask

    task automatic test_row0();
        drive_line(400, 45, 1'b0, 3'd0);
    endtask

    task automatic test_row_wrap();
        for (int y = 401; y <= 418; y++) drive_line(y, 1, 1'b0, 3'd0);
        drive_line(419, 21, 1'b0, 3'd0);
        drive_line(420, 20, 1'b0, 3'd0);
        drive_line(421, 25, 1'b0, 3'd0);
    endtask

    task automatic test_outside();
        drive_line(399, 30, 1'b0, 3'd0);
    endtask

    task automatic test_scroll();
        int want_first;
        pulse_frame(3'd7);
        pulse_frame(3'd7);
        pulse_frame(3'd7);
        drive_line(400, 25, 1'b0, 3'd0);
`ifdef GROUND_SCROLL_EN
        want_first = 1;
`else
        want_first = 0;
`endif
        DrawX       = 10'd0;
        DrawY       = 10'd400;
        pixel_valid = 1'b1;
        tick();
        total_cnt++;
        if (tile_read_address !== 9'(want_first))
            $display("FAIL scroll_first got %0d want %0d", tile_read_address, want_first);
        else pass_cnt++;
        idle(2);
        // frame_start on a line start affects only the following line.
        drive_line(400, 22, 1'b1, 3'd7);
        drive_line(401, 22, 1'b0, 3'd0);
        for (int f = 0; f < 4; f++) pulse_frame(3'd5);
        drive_line(400, 22, 1'b0, 3'd0);
    endtask

    task automatic test_reset_midline();
        for (int x = 0; x <= 300; x++) begin
            DrawX       = 10'(x);
            DrawY       = 10'd400;
            pixel_valid = 1'b1;
            tick();
        end
        total_cnt++;
        if (ground_valid !== 1'b1)
            $display("FAIL midline_valid got %b want 1", ground_valid);
        else pass_cnt++;
        #1 Reset_n = 1'b0;
        #1;
        total_cnt++;
        if (tile_read_address !== 9'd0 || ground_valid !== 1'b0 || ground_color !== 12'd0 || ground_opaque !== 1'b0)
            $display("FAIL async_reset got a=%0d v=%b c=%h o=%b want all 0", tile_read_address, ground_valid, ground_color, ground_opaque);
        else pass_cnt++;
        pixel_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #3 Reset_n = 1'b1;
        exp_phase = 0;
        exp_row   = 0;
        idle(2);
        drive_line(400, 22, 1'b0, 3'd0);
    endtask

    initial begin
        test_reset();
        test_row0();
        test_row_wrap();
        test_outside();
        test_scroll();
        test_reset_midline();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ground_tile_scanner.md
# ground_tile_scanner

Pixel-pipeline stage directly upstream of the 20x20 ground-tile ROM: it converts the VGA raster position into the ROM's 9-bit read address and registers the returned 12-bit color. It tracks tile row and column with incremental counters instead of dividers, and applies a per-frame horizontal scroll phase. Output is a 2-cycle-latency ground color plus an opaque flag for the downstream priority mux against Mario, enemies and background.

## Interface
- TILE_W, 20, tile width in pixels
- TILE_H, 20, tile height in pixels
- GROUND_TOP, 400, first screen row of the ground strip
- KEY_COLOR, 12'h808, transparent key color; never reported opaque
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- pixel_valid  in  1  DrawX/DrawY denote a visible pixel this cycle
- frame_start  in  1  one-cycle pulse at start of vertical blank
- scroll_step  in  3  pixels to advance the scroll phase per frame, 0..7
- tile_read_address  out  9  address to the tile ROM, row*TILE_W+col
- tile_color  in  12  combinational color returned by the tile ROM
- ground_valid  out  1  ground_color/ground_opaque refer to a visible pixel
- ground_color  out  12  registered tile color
- ground_opaque  out  1  pixel is in the ground strip and its color is not KEY_COLOR

## Operation
- scroll_phase (5 b, 0..TILE_W-1): on frame_start, phase <= (phase + scroll_step) mod TILE_W using a single conditional subtract; sum is at most 26.
- Column counter col (5 b): on a valid pixel with DrawX==0, col <= scroll_phase; on any other valid pixel, col <= col+1, wrapping from TILE_W-1 to 0. Hold when pixel_valid is low.
- Row tracking: row (5 b) and row_base (9 b, = row*TILE_W) update at a valid pixel with DrawX==0. If DrawY==GROUND_TOP, both are cleared. If DrawY>GROUND_TOP, row is incremented and row_base += TILE_W; when row goes from TILE_H-1 to 0, row_base is also cleared. Otherwise both hold.
- Stage 1 (address register): tile_read_address <= row_base_next + col_next, where *_next are the values being loaded this cycle. Maximum is 380+19 = 399. in_ground_s1 <= pixel_valid && DrawY>=GROUND_TOP. valid_s1 <= pixel_valid.
- Stage 2 (output register): ground_color <= tile_color. ground_opaque <= in_ground_s1 && tile_color!=KEY_COLOR. ground_valid <= valid_s1.
- Outside the ground strip, the address is still generated but ground_opaque is 0.
- frame_start together with a valid pixel: the phase update takes effect at the next line start. The current line is unaffected.

## Timing
- Reset values: tile_read_address=0, ground_color=0, ground_opaque=0, ground_valid=0, scroll_phase=0, col=0, row=0, row_base=0.
- Reset_n is asserted asynchronously at any time, including mid-line. The pipeline flushes, and the valid/opaque outputs drop immediately. Release is synchronous to Clk, and the first valid output follows 2 cycles after the first valid pixel.
- Latency: the pixel presented at cycle N appears on ground_* at cycle N+2. The ROM path is combinational between the two registers.
- Throughput: one pixel per cycle, with no stalls and no backpressure.

## Configuration
- GROUND_SCROLL_EN defined: scroll_phase advances on frame_start as described.
- GROUND_SCROLL_EN undefined: the scroll_phase register and adder are removed. The phase is constant 0, every line starts at col=0, and scroll_step and frame_start are ignored (frame_start has no effect).

## Test plan
- Reset, then a full line at DrawY=400 with phase 0 -> addresses 0,1,..,19,0,1,..; ground_valid rises 2 cycles after pixel_valid; ground_opaque follows the ROM color != 12'h808.
- Line at DrawY=421 (row 1) -> addresses start at 20, run to 39, wrap to 20; DrawY=419 -> addresses 380..399, and the next line (420) returns to 0..19.
- scroll_step=7 over 3 frame_start pulses -> phase 7, 14, then 1; the next line at DrawY=400 starts at address 1.
- DrawY=399 -> ground_opaque=0 on every pixel, even for opaque ROM colors.
- Reset_n pulsed low mid-line at DrawX=300 -> all outputs 0 immediately; after release, a line at DrawY=400 restarts at address 0.
- Build without GROUND_SCROLL_EN, scroll_step=5, 4 frames -> every line starts at col 0.
